// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead add/sub unit.
//   OP_ADD / OP_SUB : encodings of the Add_ctrl input
//   CLA_GROUP       : width of one carry-lookahead group
//   flags_t         : registered result flags {c_out, v, z, n}
//   cla4_carries    : carries into each bit of a 4-bit group
//   cla4_gen        : group generate of a 4-bit group
package cla_pkg;

  localparam logic OP_ADD    = 1'b1;
  localparam logic OP_SUB    = 1'b0;
  localparam int   CLA_GROUP = 4;

  typedef struct packed {
    logic c_out;
    logic v;
    logic z;
    logic n;
  } flags_t;

  // Two-level sum-of-products lookahead: carry into bits 0..3 of a group.
  function automatic logic [3:0] cla4_carries(input logic [3:0] g,
                                              input logic [3:0] p,
                                              input logic       cin);
    logic [3:0] c;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) |
           (p[2] & p[1] & p[0] & cin);
    return c;
  endfunction

  function automatic logic cla4_gen(input logic [3:0] g, input logic [3:0] p);
    return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) |
           (p[3] & p[2] & p[1] & g[0]);
  endfunction

endpackage

// File: rtl/cla_slice.sv
// Combinational carry-lookahead slice of width S.
// Bits are grouped in CLA_GROUP-bit groups; group generate/propagate feed a
// group-carry chain, and each group resolves its internal carries by lookahead.
// A width that is not a multiple of the group size is zero-padded at the top.
// Ports:
//   a, b   : slice operands (b already inverted for subtract)
//   cin    : carry into bit 0
//   sum    : slice sum
//   cout   : carry out of bit S-1
//   c_msb  : carry into bit S-1 (used by the top slice for signed overflow)
module cla_slice
  import cla_pkg::*;
#(
  parameter int S = 8
) (
  input  logic [S-1:0] a,
  input  logic [S-1:0] b,
  input  logic         cin,
  output logic [S-1:0] sum,
  output logic         cout,
  output logic         c_msb
);

  localparam int NG = (S + CLA_GROUP - 1) / CLA_GROUP;
  localparam int SP = NG * CLA_GROUP;

  logic [SP-1:0] g;
  logic [SP-1:0] p;
  logic [SP:0]   c;
  logic [NG:0]   cg;

  always_comb begin
    g        = '0;
    p        = '0;
    c        = '0;
    cg       = '0;
    g[S-1:0] = a & b;
    p[S-1:0] = a ^ b;
    cg[0]    = cin;
    for (int j = 0; j < NG; j++) begin
      cg[j+1] = cla4_gen(g[j*CLA_GROUP +: CLA_GROUP], p[j*CLA_GROUP +: CLA_GROUP]) |
                ((&p[j*CLA_GROUP +: CLA_GROUP]) & cg[j]);
    end
    for (int j = 0; j < NG; j++) begin
      c[j*CLA_GROUP +: CLA_GROUP] = cla4_carries(g[j*CLA_GROUP +: CLA_GROUP],
                                                 p[j*CLA_GROUP +: CLA_GROUP], cg[j]);
    end
    c[SP] = cg[NG];
  end

  assign sum   = p[S-1:0] ^ c[S-1:0];
  assign cout  = c[S];
  assign c_msb = c[S-1];

endmodule

// File: rtl/cla_addsub_pipe.sv
// Pipelined signed adder/subtractor built from STAGES carry-lookahead slices.
// An intake register captures A, the transformed B and the carry-in; each of
// the STAGES stages then adds one W/STAGES-bit slice and registers its carry
// for the next stage. Result latency is STAGES edges after the accepting edge.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand beat handshake
//   A, B                 : signed operands
//   Add_ctrl             : 1 = A+B, 0 = A-B
//   Sat_en               : saturate the signed result on overflow
//   out_valid / out_ready: result beat handshake
//   SUM                  : signed result (after saturation)
//   C_out, v, Z, N       : carry out, signed overflow, zero, negative
//
// Handshake: a beat moves in on in_valid && in_ready and a result moves out on
// out_valid && out_ready. The whole pipe stalls while out_valid && !out_ready;
// in_ready is the inverse of that stall, every register holds during it, and
// bubbles are carried along (never squeezed) so ordering is preserved.
module cla_addsub_pipe
  import cla_pkg::*;
#(
  parameter int W      = 16,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         Add_ctrl,
  input  logic         Sat_en,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] SUM,
  output logic         C_out,
  output logic         v,
  output logic         Z,
  output logic         N
);

  localparam int S = W / STAGES;
  localparam int L = STAGES - 1;

  // Rank k holds the inputs of stage k. a_q/b_q are shifted right by S per
  // rank so the next slice is always in the low bits; acc_q collects finished
  // slices from the top, landing in natural bit order after the last stage.
  logic         vld_q [STAGES];
  logic [W-1:0] a_q   [STAGES];
  logic [W-1:0] b_q   [STAGES];
  logic [W-1:0] acc_q [STAGES];
  logic         c_q   [STAGES];
  logic         sat_q [STAGES];
  logic         sgn_q [STAGES];

  logic [S-1:0] s_sum   [STAGES];
  logic         s_cout  [STAGES];
  logic         s_cmsb  [STAGES];
  logic [W-1:0] acc_nxt [STAGES];

  logic         stall;
  logic [W-1:0] b_eff;
  logic         cin0;
  logic         ovf;
  logic [W-1:0] res;
  flags_t       flags_q;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  assign b_eff = (Add_ctrl == OP_ADD) ? B : ~B;
  assign cin0  = (Add_ctrl == OP_SUB);

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    cla_slice #(.S(S)) u_slice (
      .a     (a_q[k][S-1:0]),
      .b     (b_q[k][S-1:0]),
      .cin   (c_q[k]),
      .sum   (s_sum[k]),
      .cout  (s_cout[k]),
      .c_msb (s_cmsb[k])
    );
    assign acc_nxt[k] = (acc_q[k] >> S) | (W'(s_sum[k]) << (W - S));
  end

  // Overflow from the top slice; saturation clamps toward the sign of A.
  assign ovf = s_cmsb[L] ^ s_cout[L];
  assign res = (sat_q[L] && ovf) ?
               (sgn_q[L] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}}) :
               acc_nxt[L];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= 1'b0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        acc_q[k] <= '0;
        c_q[k]   <= 1'b0;
        sat_q[k] <= 1'b0;
        sgn_q[k] <= 1'b0;
      end
    end else if (!stall) begin
      vld_q[0] <= in_valid;
      if (in_valid) begin
        a_q[0]   <= A;
        b_q[0]   <= b_eff;
        acc_q[0] <= '0;
        c_q[0]   <= cin0;
        sat_q[0] <= Sat_en;
        sgn_q[0] <= A[W-1];
      end
      for (int k = 1; k < STAGES; k++) begin
        vld_q[k] <= vld_q[k-1];
        if (vld_q[k-1]) begin
          a_q[k]   <= a_q[k-1] >> S;
          b_q[k]   <= b_q[k-1] >> S;
          acc_q[k] <= acc_nxt[k-1];
          c_q[k]   <= s_cout[k-1];
          sat_q[k] <= sat_q[k-1];
          sgn_q[k] <= sgn_q[k-1];
        end
      end
    end
  end

  // Output register only loads on a real beat so SUM keeps the last result
  // while bubbles pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      SUM       <= '0;
      flags_q   <= '0;
    end else if (!stall) begin
      out_valid <= vld_q[L];
      if (vld_q[L]) begin
        SUM           <= res;
        flags_q.c_out <= s_cout[L];
        flags_q.v     <= ovf;
        flags_q.z     <= (res == '0);
        flags_q.n     <= res[W-1];
      end
    end
  end

  assign C_out = flags_q.c_out;
  assign v     = flags_q.v;
  assign Z     = flags_q.z;
  assign N     = flags_q.n;

endmodule

// File: tb/tb_cla_addsub_pipe.sv
module tb_cla_addsub_pipe;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // ---------------- 8-bit, 2-stage instance ----------------
  logic       in_valid_8, in_ready_8, add_8, sat_8, out_valid_8, out_ready_8;
  logic       c_out_8, v_8, z_8, n_8;
  logic [7:0] a_8, b_8, sum_8;

  cla_addsub_pipe #(.W(8), .STAGES(2)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_8), .in_ready(in_ready_8),
    .A(a_8), .B(b_8), .Add_ctrl(add_8), .Sat_en(sat_8),
    .out_valid(out_valid_8), .out_ready(out_ready_8),
    .SUM(sum_8), .C_out(c_out_8), .v(v_8), .Z(z_8), .N(n_8)
  );

  // ---------------- 32-bit, 4-stage instance ----------------
  logic        in_valid_32, in_ready_32, add_32, sat_32, out_valid_32, out_ready_32;
  logic        c_out_32, v_32, z_32, n_32;
  logic [31:0] a_32, b_32, sum_32;

  cla_addsub_pipe #(.W(32), .STAGES(4)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_32), .in_ready(in_ready_32),
    .A(a_32), .B(b_32), .Add_ctrl(add_32), .Sat_en(sat_32),
    .out_valid(out_valid_32), .out_ready(out_ready_32),
    .SUM(sum_32), .C_out(c_out_32), .v(v_32), .Z(z_32), .N(n_32)
  );

  int checks = 0;
  int errors = 0;

  // Expected result packed as {SUM, C_out, v, Z, N}
  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        add;
    logic        sat;
    logic [11:0] exp;
  } vec_t;

  vec_t basic[6];
  vec_t tbl[8];

  logic [11:0] exp_q[$];
  logic [35:0] exp_w_q[$];

  // ---------------- driver tasks ----------------
  task automatic drive8(input vec_t x);
    in_valid_8 = 1'b1;
    a_8 = x.a; b_8 = x.b; add_8 = x.add; sat_8 = x.sat;
  endtask

  task automatic idle8();
    in_valid_8 = 1'b0;
    a_8 = 8'($urandom); b_8 = 8'($urandom);
    add_8 = 1'($urandom); sat_8 = 1'($urandom);
  endtask

  function automatic logic [11:0] obs8();
    return {sum_8, c_out_8, v_8, z_8, n_8};
  endfunction

  function automatic logic [35:0] obs32();
    return {sum_32, c_out_32, v_32, z_32, n_32};
  endfunction

  // Reference for the 32-bit run: overflow from operand/result signs.
  function automatic logic [35:0] model32(input logic [31:0] a, input logic [31:0] b,
                                          input logic add, input logic sat);
    logic [32:0] t;
    logic [31:0] s;
    logic        c, ov;
    t  = {1'b0, a} + {1'b0, (add ? b : ~b)} + {32'd0, ~add};
    s  = t[31:0];
    c  = t[32];
    ov = add ? ((a[31] == b[31]) && (s[31] != a[31]))
             : ((a[31] != b[31]) && (s[31] != a[31]));
    if (sat && ov) s = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    return {s, c, ov, (s == 32'd0), s[31]};
  endfunction

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic load_tables();
    basic[0] = '{8'h00, 8'h00, 1'b0, 1'b0, {8'h00, 4'b1010}};
    basic[1] = '{8'h02, 8'h03, 1'b1, 1'b0, {8'h05, 4'b0000}};
    basic[2] = '{8'h7F, 8'h7F, 1'b1, 1'b0, {8'hFE, 4'b0101}};
    basic[3] = '{8'h7F, 8'h7F, 1'b1, 1'b1, {8'h7F, 4'b0100}};
    basic[4] = '{8'h80, 8'h7F, 1'b0, 1'b0, {8'h01, 4'b1100}};
    basic[5] = '{8'h80, 8'h7F, 1'b0, 1'b1, {8'h80, 4'b1101}};
    tbl[0]   = '{8'hFF, 8'hFF, 1'b1, 1'b0, {8'hFE, 4'b1001}};
    tbl[1]   = '{8'hFE, 8'hFD, 1'b0, 1'b0, {8'h01, 4'b1000}};
    tbl[2]   = '{8'h0A, 8'h14, 1'b1, 1'b0, {8'h1E, 4'b0000}};
    tbl[3]   = '{8'h64, 8'h32, 1'b0, 1'b0, {8'h32, 4'b1000}};
    tbl[4]   = '{8'h32, 8'h64, 1'b0, 1'b0, {8'hCE, 4'b0001}};
    tbl[5]   = '{8'h55, 8'hAB, 1'b1, 1'b0, {8'h00, 4'b1010}};
    tbl[6]   = '{8'h80, 8'h80, 1'b1, 1'b1, {8'h80, 4'b1101}};
    tbl[7]   = '{8'h05, 8'h05, 1'b0, 1'b0, {8'h00, 4'b1010}};
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    idle8();
    out_ready_8 = 1'b1;
    in_valid_32 = 1'b0; a_32 = '0; b_32 = '0; add_32 = 1'b1; sat_32 = 1'b0;
    out_ready_32 = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (out_valid_8 !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid_8); end
    checks++; if (in_ready_8 !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready_8); end
    checks++; if (obs8() !== 12'h000) begin errors++; $display("FAIL reset_sum_flags: got %h expected 000", obs8()); end
    checks++; if (out_valid_32 !== 1'b0 || in_ready_32 !== 1'b1) begin errors++; $display("FAIL reset_w32: got ov=%b ir=%b expected ov=0 ir=1", out_valid_32, in_ready_32); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic_ops();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); drive8(basic[i]);
      @(negedge clk); idle8();
      checks++; if (out_valid_8 !== 1'b0) begin errors++; $display("FAIL basic%0d_early1: got out_valid %b expected 0", i, out_valid_8); end
      @(negedge clk);
      checks++; if (out_valid_8 !== 1'b0) begin errors++; $display("FAIL basic%0d_early2: got out_valid %b expected 0", i, out_valid_8); end
      @(negedge clk);
      checks++; if (out_valid_8 !== 1'b1) begin errors++; $display("FAIL basic%0d_valid: got out_valid %b expected 1", i, out_valid_8); end
      checks++; if (obs8() !== basic[i].exp) begin errors++; $display("FAIL basic%0d_result: got %h expected %h", i, obs8(), basic[i].exp); end
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c >= 3 && c <= 10) begin
        checks++; if (out_valid_8 !== 1'b1) begin errors++; $display("FAIL b2b_valid%0d: got %b expected 1", c - 3, out_valid_8); end
        checks++; if (obs8() !== tbl[c-3].exp) begin errors++; $display("FAIL b2b_result%0d: got %h expected %h", c - 3, obs8(), tbl[c-3].exp); end
      end else begin
        checks++; if (out_valid_8 !== 1'b0) begin errors++; $display("FAIL b2b_gap%0d: got out_valid %b expected 0", c, out_valid_8); end
      end
      if (c < 8) drive8(tbl[c]); else idle8();
    end
  endtask

  task automatic test_backpressure();
    int sent = 0;
    int got  = 0;
    logic [11:0] hold = '0;
    bit holding = 1'b0;
    exp_q.delete();
    for (int cyc = 0; cyc < 80 && got < 12; cyc++) begin
      @(negedge clk);
      out_ready_8 = !(cyc >= 5 && cyc < 10);
      #1;
      if (out_valid_8 && !out_ready_8) begin
        checks++; if (in_ready_8 !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc%0d: got %b expected 0", cyc, in_ready_8); end
        if (holding) begin
          checks++; if (obs8() !== hold) begin errors++; $display("FAIL bp_hold cyc%0d: got %h expected %h", cyc, obs8(), hold); end
        end else begin
          hold = obs8(); holding = 1'b1;
        end
      end else begin
        holding = 1'b0;
      end
      if (out_valid_8 && out_ready_8) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL bp_extra: got result %h expected none", obs8());
        end else begin
          logic [11:0] e;
          e = exp_q.pop_front();
          if (obs8() !== e) begin errors++; $display("FAIL bp_result%0d: got %h expected %h", got, obs8(), e); end
        end
        got++;
      end
      if (sent < 12) begin
        drive8(tbl[sent % 8]);
        if (in_ready_8) begin exp_q.push_back(tbl[sent % 8].exp); sent++; end
      end else begin
        idle8();
      end
    end
    checks++; if (got !== 12) begin errors++; $display("FAIL bp_count: got %0d results expected 12", got); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL bp_leftover: got %0d pending expected 0", exp_q.size()); end
    @(negedge clk); idle8(); out_ready_8 = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_midflight();
    @(negedge clk); drive8(tbl[0]);
    @(negedge clk); drive8(tbl[1]);
    @(negedge clk); idle8();
    @(negedge clk);
    checks++; if (out_valid_8 !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %b expected 1", out_valid_8); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid_8 !== 1'b0) begin errors++; $display("FAIL mid_async_valid: got %b expected 0", out_valid_8); end
    checks++; if (obs8() !== 12'h000) begin errors++; $display("FAIL mid_async_clear: got %h expected 000", obs8()); end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++; if (out_valid_8 !== 1'b0) begin errors++; $display("FAIL mid_stale%0d: got out_valid %b expected 0", i, out_valid_8); end
    end
    drive8(basic[1]);
    @(negedge clk); idle8();
    repeat (2) @(negedge clk);
    checks++; if (out_valid_8 !== 1'b1 || obs8() !== basic[1].exp) begin errors++; $display("FAIL mid_recover: got ov=%b %h expected ov=1 %h", out_valid_8, obs8(), basic[1].exp); end
  endtask

  task automatic test_wide();
    int sent = 0;
    int got  = 0;
    @(negedge clk);
    in_valid_32 = 1'b1; a_32 = 32'h7FFF_FFFF; b_32 = 32'h0000_0001; add_32 = 1'b1; sat_32 = 1'b0;
    @(negedge clk); in_valid_32 = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (out_valid_32 !== 1'b0) begin errors++; $display("FAIL w32_early: got out_valid %b expected 0", out_valid_32); end
    @(negedge clk);
    checks++; if (out_valid_32 !== 1'b1) begin errors++; $display("FAIL w32_valid: got %b expected 1", out_valid_32); end
    checks++; if (obs32() !== {32'h8000_0000, 4'b0101}) begin errors++; $display("FAIL w32_result: got %h expected %h", obs32(), {32'h8000_0000, 4'b0101}); end

    exp_w_q.delete();
    for (int cyc = 0; cyc < 6000 && got < 1000; cyc++) begin
      @(negedge clk);
      out_ready_32 = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid_32 && out_ready_32) begin
        checks++;
        if (exp_w_q.size() == 0) begin
          errors++; $display("FAIL w32_extra: got %h expected none", obs32());
        end else begin
          logic [35:0] e;
          e = exp_w_q.pop_front();
          if (obs32() !== e) begin errors++; $display("FAIL w32_rand%0d: got %h expected %h", got, obs32(), e); end
        end
        got++;
      end
      a_32 = pick32(); b_32 = pick32();
      add_32 = 1'($urandom); sat_32 = 1'($urandom);
      in_valid_32 = (sent < 1000) && ($urandom_range(0, 4) != 0);
      if (in_valid_32 && in_ready_32) begin
        exp_w_q.push_back(model32(a_32, b_32, add_32, sat_32));
        sent++;
      end
    end
    in_valid_32 = 1'b0;
    checks++; if (got !== 1000) begin errors++; $display("FAIL w32_count: got %0d results expected 1000", got); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    load_tables();
    test_reset();
    test_basic_ops();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_wide();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/cla_addsub_pipe.md
Name: cla_addsub_pipe

Overview:
- Parametrised, pipelined signed adder/subtractor. Successor to the 8-bit combinational CLA add/sub unit.
- Operand width is split into STAGES carry-lookahead slices, with the carry registered between slices.
- Adds valid/ready handshaking, optional signed saturation and zero/negative flags.
- Sits between operand-fetch and writeback in the datapath; sustains one operation per cycle when not stalled.

Parameters:
- W, 16, operand/result width in bits; must be a multiple of STAGES and >= 4.
- STAGES, 2, number of pipeline stages (= latency); each stage computes W/STAGES bits.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  unit can accept a beat this cycle
- A  in  W  signed operand A
- B  in  W  signed operand B
- Add_ctrl  in  1  1 = A+B, 0 = A-B
- Sat_en  in  1  1 = saturate signed result on overflow
- out_valid  out  1  result beat valid
- out_ready  in  1  downstream accepts result
- SUM  out  W  signed result
- C_out  out  1  carry out of MSB (subtract: 1 = no borrow)
- v  out  1  signed overflow, reported even when saturated
- Z  out  1  SUM == 0, evaluated after saturation
- N  out  1  SUM[W-1], evaluated after saturation

Behaviour:
- Reset: asynchronous on rst_n low. All stage valids, out_valid, SUM, C_out, v, Z and N go to 0. in_ready is 1 out of reset.
- Operand transform at intake: B_eff = Add_ctrl ? B : ~B; cin0 = ~Add_ctrl.
- Stage k (k = 0..STAGES-1) computes bits [k*S +: S] (S = W/STAGES) with a 4-bit-group CLA. Its carry-in is cin0 for k = 0, otherwise the carry registered by stage k-1.
- Upper operand slices, Add_ctrl and Sat_en travel down the pipe alongside their beat.
- Final stage:
  - C_out = carry out of the MSB slice.
  - v = carry-into-MSB XOR carry-out-of-MSB.
  - If Sat_en && v: SUM = A[W-1] ? {1,0..0} : {0,1..1}, i.e. saturate toward the sign of A.
  - Otherwise SUM = raw sum. Z and N are computed from the final SUM.
- Latency: a beat accepted at edge t appears with out_valid=1 after edge t+STAGES.
- Handshake:
  - A beat transfers in when in_valid && in_ready.
  - A result transfers out when out_valid && out_ready.
  - Global stall = out_valid && !out_ready. in_ready = !stall.
  - While stalled, every pipeline register holds, and SUM and the flags stay stable.
- No bubbles are inserted. Back-to-back beats yield back-to-back results while out_ready=1.
- An empty slot (in_valid=0) propagates as a valid=0 bubble. Bubbles are not squeezed out while the pipe is stalled.
- Simultaneous out-transfer and in-transfer in the same cycle is legal; throughput is 1/cycle.
- Reset asserted mid-operation discards all in-flight beats. No result is emitted for them.
- Inputs are sampled only on the accepting edge. A, B and the modes may change freely otherwise.

Decomposition:
- Shared package cla_pkg: constants OP_ADD=1'b1 and OP_SUB=1'b0, CLA_GROUP=4, and a flags struct {C_out, v, Z, N}.
- Sub-module cla_slice (combinational, parametrised width S):
  - Generate/propagate over 4-bit groups plus group lookahead.
  - Outputs sum slice, carry out, and carry into the slice MSB (used by the top slice for v).
- The top module instantiates STAGES slices plus the stage registers, stall logic and saturation mux.

Test Plan (W=8, STAGES=2 unless stated):
- Reset and basic ops:
  - Apply reset; 0-0 sub -> after 2 cycles SUM=0x00, C_out=1, Z=1, v=0.
  - 2+3 add -> SUM=0x05, C_out=0, N=0.
- Overflow wrap vs saturate:
  - 127+127, Sat_en=0 -> SUM=0xFE, v=1.
  - Sat_en=1 -> SUM=0x7F, v=1.
  - -128-127 sub, Sat_en=0 -> SUM=0x01, C_out=1, v=1.
  - Sat_en=1 -> SUM=0x80, N=1.
- Throughput: 8 back-to-back beats with out_ready=1 -> 8 consecutive out_valid cycles in order, first at cycle 2. Include -1+-1 -> 0xFE, C_out=1, N=1 and -2-(-3) -> 0x01, C_out=1.
- Backpressure: out_ready=0 for 5 cycles mid-stream.
  - in_ready drops the cycle after out_valid rises.
  - SUM and flags hold stable.
  - No beat is lost or duplicated after release.
- Reset mid-flight: assert rst_n=0 asynchronously with 2 beats in the pipe -> out_valid=0 immediately; no stale result after release.
- Generality: W=32, STAGES=4; 0x7FFFFFFF+1 -> SUM=0x80000000, v=1 at cycle 4. A random 1000-beat run must match a reference model.
